spi_host_xfer: RTL

- SPI initiator (mode 0, MSB first) for the board's register-mapped SPI peripheral (chip ID 8'h07, LED/switch registers).
- Accepts one register request per handshake and serialises it into a two-byte, CS-framed transaction.
- Byte 0 = {W, 4'b0000, A2:A0}, with W=1 for read. Byte 1 = write data, or 8'h00 for a read.
- For a read, returns the byte shifted in on MISO during byte 1.
- Sits between host-side control logic (FSM or UART bridge) and the board's SPI pins.

---
 rtl/spi_host_pkg.sv | 29 ++
 rtl/spi_byte_shifter.sv | 48 ++++
 rtl/spi_host_xfer.sv | 100 ++++++++++
 3 files changed

// File: rtl/spi_host_pkg.sv
// Shared types and constants for the board SPI register host.
// Command byte layout: {W, 4'b0000, A2:A0}, W=1 means read.
package spi_host_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } state_e;

   localparam int         RW_BIT      = 7;
   localparam logic [7:0] CHIP_ID     = 8'h07;
   localparam logic [2:0] ADDR_ID     = 3'd0;
   localparam logic [2:0] ADDR_SW_LO  = 3'd1;
   localparam logic [2:0] ADDR_SW_HI  = 3'd2;
   localparam logic [2:0] ADDR_LED_LO = 3'd3;
   localparam logic [2:0] ADDR_LED_HI = 3'd4;

   function automatic logic [7:0] mk_cmd(input logic rd, input logic [2:0] addr);
      logic [7:0] c;
      c         = {5'b0, addr};
      c[RW_BIT] = rd;
      return c;
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 single-byte engine: each enabled tick toggles sclk; rising ticks
// sample miso, falling ticks advance mosi. done flags the 16th half-period.
module spi_byte_shifter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       en,
   input  logic       tick,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic [7:0] rx_data,
   output logic       done
);

   logic [7:0] tx_sr;
   logic [3:0] hp;

   assign done = en && tick && (hp == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr   <= '0;
         hp      <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         rx_data <= '0;
      end else if (load) begin
         // load also serves as the final falling edge of the previous byte
         tx_sr <= load_data;
         mosi  <= load_data[7];
         hp    <= '0;
         sclk  <= 1'b0;
      end else if (en && tick) begin
         hp <= hp + 4'd1;
         if (!hp[0]) begin
            sclk    <= 1'b1;
            rx_data <= {rx_data[6:0], miso};
         end else begin
            sclk  <= 1'b0;
            tx_sr <= {tx_sr[6:0], 1'b0};
            mosi  <= done ? 1'b0 : tx_sr[6];
         end
      end
   end

endmodule

// File: rtl/spi_host_xfer.sv
// SPI register host: frames one request as a two-byte CS-low transaction
// (command, then data) and returns the byte read back during byte 1.
module spi_host_xfer
   import spi_host_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_read,
   input  logic [2:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   state_e     state, state_nxt;
   logic [7:0] cnt;
   logic [7:0] dat;
   logic       rd_q;
   logic       byte_idx;
   logic       accept, tick, gap_end;
   logic       sh_load, sh_en, sh_done;
   logic [7:0] sh_data, sh_rx;

   assign accept    = req_valid && (state == IDLE);
   assign tick      = (cnt == 8'(CLK_DIV - 1));
   assign gap_end   = (cnt == 8'(CS_GAP - 1));
   assign sh_en     = (state == SHIFT);
   assign sh_load   = accept || (sh_done && !byte_idx);
   assign sh_data   = accept ? mk_cmd(req_read, req_addr) : dat;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == DONE);
   assign cs_n      = !((state == SETUP) || (state == SHIFT) || (state == HOLD));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_valid) state_nxt = SETUP;
         SETUP:   if (tick) state_nxt = SHIFT;
         SHIFT:   if (sh_done && byte_idx) state_nxt = HOLD;
         HOLD:    if (tick) state_nxt = GAP;
         GAP:     if (gap_end) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         dat       <= '0;
         rd_q      <= 1'b0;
         byte_idx  <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_nxt;
         // divider restarts on every state entry; GAP counts CS_GAP, not CLK_DIV
         if ((state_nxt != state) || (state == IDLE) || ((state != GAP) && tick))
            cnt <= '0;
         else
            cnt <= cnt + 8'd1;
         if (accept) begin
            rd_q     <= req_read;
            dat      <= req_read ? 8'h00 : req_wdata;
            byte_idx <= 1'b0;
         end else if (sh_done && !byte_idx) begin
            byte_idx <= 1'b1;
         end
         if ((state == GAP) && gap_end && rd_q)
            rsp_rdata <= sh_rx;
      end
   end

   spi_byte_shifter u_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (sh_load),
      .load_data (sh_data),
      .en        (sh_en),
      .tick      (tick),
      .miso      (miso),
      .sclk      (sclk),
      .mosi      (mosi),
      .rx_data   (sh_rx),
      .done      (sh_done)
   );

endmodule
